// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall sequencer: ID/EX/MEM hazard
// inputs going in, stage enables, bubble request and stall statistics coming out.
interface hazard_stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [1:0]  id_tuse_rs;
  logic [1:0]  id_tuse_rt;
  logic        id_is_md;
  logic [4:0]  ex_dst;
  logic [1:0]  ex_tnew;
  logic [4:0]  mem_dst;
  logic [1:0]  mem_tnew;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic        pc_en;
  logic        en01;
  logic        flush12;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
    output ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
    input  pc_en, en01, flush12, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
    input  ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
    output pc_en, en01, flush12, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus the mult/div busy FSM.
// Optional feature macro: STALL_STATS_EN builds a saturating stalled-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_t        state_p1;
  md_state_t        state_d;
  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_d;

  logic hz_rs;
  logic hz_rt;
  logic hz_md;
  logic stall;

  // A source operand hazards when its producer's result arrives later than the
  // consumer needs it; register 0 is hard-wired and never produced.
  function automatic logic data_hz(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ex_dst,
    input logic [1:0] ex_tnew,
    input logic [4:0] mem_dst,
    input logic [1:0] mem_tnew
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (src == ex_dst)  && (ex_tnew  > tuse);
    mem_hit = (src == mem_dst) && (mem_tnew > tuse);
    return (src != 5'd0) && (ex_hit || mem_hit);
  endfunction

  function automatic logic [CNT_W-1:0] count_down(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // ---- Stage 0: combinational hazard detection ----
  always_comb begin
    hz_rs = data_hz(bus.id_rs, bus.id_tuse_rs, bus.ex_dst, bus.ex_tnew,
                    bus.mem_dst, bus.mem_tnew);
    hz_rt = data_hz(bus.id_rt, bus.id_tuse_rt, bus.ex_dst, bus.ex_tnew,
                    bus.mem_dst, bus.mem_tnew);
    hz_md = bus.id_is_md && (bus.md_busy || bus.ex_md_start);
    // Held at zero in reset so IF/ID stays enabled and loads its reset values.
    stall = reset && (hz_rs || hz_rt || hz_md);
  end

  assign bus.pc_en   = ~stall;
  assign bus.en01    = ~stall;
  assign bus.flush12 = stall;

  // ---- Stage 1: mult/div busy countdown ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= MD_IDLE;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_d;
      cnt_p1   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_p1;
    cnt_d   = cnt_p1;
    case (state_p1)
      MD_IDLE: begin
        cnt_d = '0;
        if (bus.ex_md_start) begin
          state_d = MD_BUSY;
          cnt_d   = bus.ex_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // A start seen here is ignored: the count is never reloaded mid-op.
        cnt_d = count_down(cnt_p1);
        if (cnt_p1 <= CNT_W'(1)) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.md_busy = (state_p1 == MD_BUSY);

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- Stage 1: stalled-cycle statistics ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_p1 <= '0;
    end else if (stall) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.stall_cnt = stall_cnt_p1;
`else
  assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: reset, data hazards, mult/div busy,
// reset mid-operation and the optional stall statistics.
module tb_hazard_stall_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   busy_len;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, got running want done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stats_exp(input logic [31:0] n);
`ifdef STALL_STATS_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic set_idle();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_tuse_rs   = 2'd3;
    bus.id_tuse_rt   = 2'd3;
    bus.id_is_md     = 1'b0;
    bus.ex_dst       = 5'd0;
    bus.ex_tnew      = 2'd0;
    bus.mem_dst      = 5'd0;
    bus.mem_tnew     = 2'd0;
    bus.ex_md_start  = 1'b0;
    bus.ex_md_is_div = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, "_pc_en"},   {31'd0, bus.pc_en},   {31'd0, ~exp_stall});
    chk({tag, "_en01"},    {31'd0, bus.en01},    {31'd0, ~exp_stall});
    chk({tag, "_flush12"}, {31'd0, bus.flush12}, {31'd0, exp_stall});
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset held low with hazard-laden inputs
    reset            = 1'b0;
    bus.id_rs        = 5'd5;
    bus.id_rt        = 5'd6;
    bus.id_tuse_rs   = 2'd0;
    bus.id_tuse_rt   = 2'd0;
    bus.id_is_md     = 1'b1;
    bus.ex_dst       = 5'd5;
    bus.ex_tnew      = 2'd3;
    bus.mem_dst      = 5'd6;
    bus.mem_tnew     = 2'd2;
    bus.ex_md_start  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    #2;
    chk_stall("rst", 1'b0);
    chk("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    tick();
    tick();
    chk("rst_md_busy_clk", {31'd0, bus.md_busy}, 32'd0);
    chk_stall("rst_clk", 1'b0);

    set_idle();
    #2 reset = 1'b1;
    tick();
    chk_stall("rel", 1'b0);
    chk("rel_md_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rel_stall_cnt", bus.stall_cnt, 32'd0);

    // Load-use against EX
    bus.ex_dst     = 5'd8;
    bus.ex_tnew    = 2'd2;
    bus.id_rs      = 5'd8;
    bus.id_tuse_rs = 2'd1;
    #1;
    chk_stall("lu", 1'b1);
    tick();
    bus.ex_tnew = 2'd0;
    #1;
    chk_stall("lu_clear", 1'b0);
    bus.ex_tnew = 2'd1;
    #1;
    chk_stall("lu_equal", 1'b0);

    // Hazard on both rs and rt still counts one stalled cycle
    bus.ex_tnew    = 2'd2;
    bus.id_rt      = 5'd8;
    bus.id_tuse_rt = 2'd0;
    #1;
    chk_stall("rsrt", 1'b1);
    tick();
    chk("rsrt_stall_cnt", bus.stall_cnt, stats_exp(32'd2));

    // Zero register never hazards; MEM-stage producer does
    set_idle();
    bus.ex_dst     = 5'd0;
    bus.ex_tnew    = 2'd2;
    bus.id_rs      = 5'd0;
    bus.id_tuse_rs = 2'd0;
    #1;
    chk_stall("zero", 1'b0);
    bus.id_rt      = 5'd9;
    bus.id_tuse_rt = 2'd0;
    bus.mem_dst    = 5'd9;
    bus.mem_tnew   = 2'd1;
    #1;
    chk_stall("mem", 1'b1);
    set_idle();
    #1;
    chk_stall("mem_clear", 1'b0);
    tick();

    // Divide: start at edge T with an MD instruction waiting in ID
    bus.ex_md_start  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    bus.id_is_md     = 1'b1;
    #1;
    chk_stall("div_T", 1'b1);
    chk("div_T_busy", {31'd0, bus.md_busy}, 32'd0);
    tick();
    bus.ex_md_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("div_busy", {31'd0, bus.md_busy}, 32'd1);
      chk("div_flush", {31'd0, bus.flush12}, 32'd1);
      if (k == 5) begin
        bus.ex_md_start  = 1'b1;
        bus.ex_md_is_div = 1'b0;
      end
      tick();
      bus.ex_md_start = 1'b0;
    end
    #1;
    chk("div_done_busy", {31'd0, bus.md_busy}, 32'd0);
    chk_stall("div_done", 1'b0);
    chk("div_stall_cnt", bus.stall_cnt, stats_exp(32'd13));

    // Multiply length, no MD instruction waiting
    set_idle();
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.md_busy) busy_len++;
      tick();
    end
    chk("mult_len", busy_len, 32'd5);

    // Multiply interrupted by reset in its second busy cycle
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    tick();
    chk("mult_busy2", {31'd0, bus.md_busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mult_rst_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("mult_rst_stall_cnt", bus.stall_cnt, 32'd0);
    tick();
    #2 reset = 1'b1;
    tick();
    bus.id_is_md = 1'b1;
    #1;
    chk_stall("mult_rst_md", 1'b0);
    chk("mult_rst_md_busy", {31'd0, bus.md_busy}, 32'd0);

    // Two more stalled cycles after reset restart the statistics
    set_idle();
    bus.mem_dst    = 5'd12;
    bus.mem_tnew   = 2'd2;
    bus.id_rs      = 5'd12;
    bus.id_tuse_rs = 2'd1;
    #1;
    chk_stall("post_lu", 1'b1);
    tick();
    tick();
    set_idle();
    #1;
    chk_stall("post_clear", 1'b0);
    chk("post_stall_cnt", bus.stall_cnt, stats_exp(32'd2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
